// File: rtl/level_controller.sv
// Whack-a-mole round FSM: times the round, raises difficulty from score, latches final score.
// Outputs follow their inputs by one clock; no backpressure, inputs are sampled every cycle.
module level_controller #(
  parameter int unsigned CLOCKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS   = 60,
  parameter logic [7:0]  L1_SCORE       = 8'd5,
  parameter logic [7:0]  L2_SCORE       = 8'd10,
  parameter logic [7:0]  L3_SCORE       = 8'd20,
  parameter logic [27:0] SPEED_L0       = 28'd100000000,
  parameter logic [27:0] SPEED_L1       = 28'd75000000,
  parameter logic [27:0] SPEED_L2       = 28'd50000000,
  parameter logic [27:0] SPEED_L3       = 28'd25000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  score,
  output logic        game,
  output logic [27:0] speed,
  output logic [1:0]  level,
  output logic [7:0]  time_left,
  output logic        game_over,
  output logic [7:0]  final_score
);

  localparam int unsigned    TW        = (CLOCKS_PER_SEC > 1) ? $clog2(CLOCKS_PER_SEC) : 1;
  localparam logic [TW-1:0]  TICK_MAX  = TW'(CLOCKS_PER_SEC - 1);
  localparam logic [7:0]     TIME_INIT = 8'(GAME_SECONDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_start_q;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic [7:0]      r_time_left, w_time_left_nxt;
  logic [1:0]      r_level, w_level_nxt;
  logic [27:0]     r_speed, w_speed_nxt;
  logic [7:0]      r_final_score, w_final_score_nxt;

  logic            w_start_pulse;
  logic            w_tick;
  logic [1:0]      w_target;
  logic [1:0]      w_level_up;

  function automatic logic [27:0] speed_of(input logic [1:0] lvl);
    case (lvl)
      2'd0:    speed_of = SPEED_L0;
      2'd1:    speed_of = SPEED_L1;
      2'd2:    speed_of = SPEED_L2;
      default: speed_of = SPEED_L3;
    endcase
  endfunction

  assign w_start_pulse = start & ~r_start_q;
  assign w_tick        = (r_tick == TICK_MAX);

  always_comb begin
    w_target = 2'd0;
    if (score >= L3_SCORE)      w_target = 2'd3;
    else if (score >= L2_SCORE) w_target = 2'd2;
    else if (score >= L1_SCORE) w_target = 2'd1;
  end

  // Level is a running maximum within the round; a falling score never slows the moles.
  assign w_level_up = (w_target > r_level) ? w_target : r_level;

  always_comb begin
    w_state_nxt       = r_state;
    w_tick_nxt        = r_tick;
    w_time_left_nxt   = r_time_left;
    w_level_nxt       = r_level;
    w_speed_nxt       = r_speed;
    w_final_score_nxt = r_final_score;

    case (r_state)
      ST_IDLE: begin
        if (w_start_pulse) begin
          w_state_nxt     = ST_PLAY;
          w_tick_nxt      = '0;
          w_time_left_nxt = TIME_INIT;
          w_level_nxt     = 2'd0;
          w_speed_nxt     = SPEED_L0;
        end
      end

      ST_PLAY: begin
        if (abort) begin
          w_state_nxt     = ST_IDLE;
          w_tick_nxt      = '0;
          w_time_left_nxt = TIME_INIT;
          w_level_nxt     = 2'd0;
          w_speed_nxt     = SPEED_L0;
        end else begin
          w_level_nxt = w_level_up;
          w_speed_nxt = speed_of(w_level_up);
          if (w_tick) begin
            w_tick_nxt = '0;
            if (r_time_left > 8'd1) begin
              w_time_left_nxt = r_time_left - 8'd1;
            end else begin
              w_time_left_nxt   = 8'd0;
              w_state_nxt       = ST_OVER;
              w_final_score_nxt = score;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end

      ST_OVER: begin
        if (abort) begin
          w_state_nxt     = ST_IDLE;
          w_tick_nxt      = '0;
          w_time_left_nxt = TIME_INIT;
          w_level_nxt     = 2'd0;
          w_speed_nxt     = SPEED_L0;
        end else if (w_start_pulse) begin
          w_state_nxt     = ST_PLAY;
          w_tick_nxt      = '0;
          w_time_left_nxt = TIME_INIT;
          w_level_nxt     = 2'd0;
          w_speed_nxt     = SPEED_L0;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_tick_nxt      = '0;
        w_time_left_nxt = TIME_INIT;
        w_level_nxt     = 2'd0;
        w_speed_nxt     = SPEED_L0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_start_q     <= 1'b0;
      r_tick        <= '0;
      r_time_left   <= TIME_INIT;
      r_level       <= 2'd0;
      r_speed       <= SPEED_L0;
      r_final_score <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_q     <= start;
      r_tick        <= w_tick_nxt;
      r_time_left   <= w_time_left_nxt;
      r_level       <= w_level_nxt;
      r_speed       <= w_speed_nxt;
      r_final_score <= w_final_score_nxt;
    end
  end

  assign game        = (r_state == ST_PLAY);
  assign game_over   = (r_state == ST_OVER);
  assign level       = r_level;
  assign speed       = r_speed;
  assign time_left   = r_time_left;
  assign final_score = r_final_score;

endmodule

// File: tb/tb_level_controller.sv
// Randomised and directed bench for level_controller with a round-level reference model.
module tb_level_controller;

  localparam int CPS = 4;
  localparam int GS  = 3;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [7:0]  score;
  logic        game;
  logic [27:0] speed;
  logic [1:0]  level;
  logic [7:0]  time_left;
  logic        game_over;
  logic [7:0]  final_score;

  int checks = 0;
  int errors = 0;

  // Reference model: round mode, edges elapsed in the round, best level reached.
  int         m_mode;   // 0 idle, 1 play, 2 over
  int         m_n;
  int         m_maxt;
  logic [7:0] m_final;
  logic       m_start_q;

  level_controller #(
    .CLOCKS_PER_SEC(CPS),
    .GAME_SECONDS(GS),
    .L1_SCORE(8'd5),
    .L2_SCORE(8'd10),
    .L3_SCORE(8'd20)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .abort(abort),
    .score(score),
    .game(game),
    .speed(speed),
    .level(level),
    .time_left(time_left),
    .game_over(game_over),
    .final_score(final_score)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int target_of(input logic [7:0] s);
    return int'(s >= 8'd20) + int'(s >= 8'd10) + int'(s >= 8'd5);
  endfunction

  function automatic logic [27:0] speed_for(input int l);
    logic [27:0] tbl [4];
    tbl[0] = 28'd100000000;
    tbl[1] = 28'd75000000;
    tbl[2] = 28'd50000000;
    tbl[3] = 28'd25000000;
    return tbl[l];
  endfunction

  function automatic logic       exp_game();  return m_mode == 1; endfunction
  function automatic logic       exp_over();  return m_mode == 2; endfunction
  function automatic int         exp_level(); return (m_mode == 0) ? 0 : m_maxt; endfunction
  function automatic logic [7:0] exp_time();
    if (m_mode == 0) return 8'(GS);
    if (m_mode == 1) return 8'(GS - m_n / CPS);
    return 8'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_maxt = 0; m_final = 8'd0; m_start_q = 1'b0;
  endtask

  task automatic step();
    logic pulse;
    @(posedge clock);
    if (!resetn) begin
      model_reset();
    end else begin
      pulse = start && !m_start_q;
      m_start_q = start;
      case (m_mode)
        0: if (pulse) begin m_mode = 1; m_n = 0; m_maxt = 0; end
        1: begin
          if (abort) m_mode = 0;
          else begin
            m_n++;
            if (target_of(score) > m_maxt) m_maxt = target_of(score);
            if (m_n == GS * CPS) begin m_mode = 2; m_final = score; end
          end
        end
        default: begin
          if (abort) m_mode = 0;
          else if (pulse) begin m_mode = 1; m_n = 0; m_maxt = 0; end
        end
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; score = 8'd0;
    model_reset();
    repeat (2) step();
    checks++; if (game !== 1'b0) begin errors++; $display("FAIL rst_game got %0b want 0", game); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_over got %0b want 0", game_over); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (speed !== 28'd100000000) begin errors++; $display("FAIL rst_speed got %0d want 100000000", speed); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL rst_time got %0d want 3", time_left); end
    checks++; if (final_score !== 8'd0) begin errors++; $display("FAIL rst_final got %0d want 0", final_score); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_round_timing();
    start = 1'b1;
    step();
    checks++; if (game !== 1'b1) begin errors++; $display("FAIL start_game got %0b want 1", game); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL start_time got %0d want 3", time_left); end
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (time_left !== exp_time()) begin errors++; $display("FAIL timing_time k=%0d got %0d want %0d", k, time_left, exp_time()); end
      checks++; if (game !== exp_game()) begin errors++; $display("FAIL timing_game k=%0d got %0b want %0b", k, game, exp_game()); end
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL expire_over got %0b want 1", game_over); end
    checks++; if (time_left !== 8'd0) begin errors++; $display("FAIL expire_time got %0d want 0", time_left); end
  endtask

  task automatic test_levels();
    logic [7:0] steps [4];
    int guard;
    logic prev_game;
    int rises;
    steps[0] = 8'd0; steps[1] = 8'd5; steps[2] = 8'd10; steps[3] = 8'd20;
    start = 1'b1; score = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      score = steps[i];
      #1;
      checks++; if (level !== 2'((i == 0) ? 0 : i - 1)) begin errors++; $display("FAIL level_latency i=%0d got %0d want %0d", i, level, (i == 0) ? 0 : i - 1); end
      step();
      checks++; if (level !== 2'(i)) begin errors++; $display("FAIL level_step i=%0d got %0d want %0d", i, level, i); end
      checks++; if (speed !== speed_for(i)) begin errors++; $display("FAIL speed_step i=%0d got %0d want %0d", i, speed, speed_for(i)); end
    end
    score = 8'd3;
    step();
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL level_hold got %0d want 3", level); end
    checks++; if (speed !== 28'd25000000) begin errors++; $display("FAIL speed_hold got %0d want 25000000", speed); end
    guard = 0;
    while (m_mode == 1 && guard < 20) begin
      score = (m_n == GS * CPS - 1) ? 8'd14 : 8'($urandom_range(0, 30));
      step();
      guard++;
    end
    checks++; if (final_score !== 8'd14) begin errors++; $display("FAIL final_latch got %0d want 14", final_score); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL final_over got %0b want 1", game_over); end
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL over_level got %0d want 3", level); end
    score = 8'd0;
    repeat (3) step();
    checks++; if (final_score !== 8'd14) begin errors++; $display("FAIL final_hold got %0d want 14", final_score); end
    start = 1'b1;
    rises = 0;
    prev_game = game;
    repeat (16) begin
      step();
      if (game && !prev_game) rises++;
      prev_game = game;
    end
    start = 1'b0;
    checks++; if (rises !== 1) begin errors++; $display("FAIL start_held_rounds got %0d want 1", rises); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL start_held_over got %0b want 1", game_over); end
    checks++; if (final_score !== m_final) begin errors++; $display("FAIL start_held_final got %0d want %0d", final_score, m_final); end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] keep;
    keep = m_final;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) begin
      score = 8'($urandom_range(0, 30));
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (game !== 1'b0) begin errors++; $display("FAIL abort_game got %0b want 0", game); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL abort_over got %0b want 0", game_over); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL abort_level got %0d want 0", level); end
    checks++; if (speed !== 28'd100000000) begin errors++; $display("FAIL abort_speed got %0d want 100000000", speed); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL abort_time got %0d want 3", time_left); end
    checks++; if (final_score !== keep) begin errors++; $display("FAIL abort_final got %0d want %0d", final_score, keep); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; score = 8'd12;
    step();
    start = 1'b0;
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    checks++; if (game !== 1'b0) begin errors++; $display("FAIL arst_game got %0b want 0", game); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
    checks++; if (speed !== 28'd100000000) begin errors++; $display("FAIL arst_speed got %0d want 100000000", speed); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL arst_time got %0d want 3", time_left); end
    checks++; if (final_score !== 8'd0) begin errors++; $display("FAIL arst_final got %0d want 0", final_score); end
    resetn = 1'b1;
    start = 1'b1; score = 8'd22;
    step();
    start = 1'b0;
    repeat (12) step();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL rerun_over got %0b want 1", game_over); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (game !== 1'b1) begin errors++; $display("FAIL restart_game got %0b want 1", game); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_over got %0b want 0", game_over); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL restart_time got %0d want 3", time_left); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL restart_level got %0d want 0", level); end
  endtask

  task automatic test_abort_expiry();
    logic [7:0] keep;
    int guard;
    keep = m_final;
    guard = 0;
    while (m_n < GS * CPS - 1 && guard < 20) begin
      score = 8'($urandom_range(0, 30));
      step();
      guard++;
    end
    abort = 1'b1;
    score = 8'd7;
    step();
    abort = 1'b0;
    checks++; if (game !== 1'b0) begin errors++; $display("FAIL abexp_game got %0b want 0", game); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL abexp_over got %0b want 0", game_over); end
    checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL abexp_time got %0d want 3", time_left); end
    checks++; if (final_score !== keep) begin errors++; $display("FAIL abexp_final got %0d want %0d", final_score, keep); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 59) == 0);
      resetn = ($urandom_range(0, 399) != 0);
      score  = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 25));
      step();
      checks++; if (game !== exp_game()) begin errors++; $display("FAIL rnd_game c=%0d got %0b want %0b", c, game, exp_game()); end
      checks++; if (game_over !== exp_over()) begin errors++; $display("FAIL rnd_over c=%0d got %0b want %0b", c, game_over, exp_over()); end
      checks++; if (level !== 2'(exp_level())) begin errors++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, exp_level()); end
      checks++; if (speed !== speed_for(exp_level())) begin errors++; $display("FAIL rnd_speed c=%0d got %0d want %0d", c, speed, speed_for(exp_level())); end
      checks++; if (time_left !== exp_time()) begin errors++; $display("FAIL rnd_time c=%0d got %0d want %0d", c, time_left, exp_time()); end
      checks++; if (final_score !== m_final) begin errors++; $display("FAIL rnd_final c=%0d got %0d want %0d", c, final_score, m_final); end
    end
    resetn = 1'b1; start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_timing();
    test_levels();
    test_abort();
    test_async_reset();
    test_abort_expiry();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
